// File: rtl/parity_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_tx
// Brief    : Serial byte transmitter: start bit, 8 data bits LSB first,
//            parity bit (even/odd), stop bit; BIT_CYCLES clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module parity_frame_tx #(
    parameter int BIT_CYCLES = 4,
    parameter int ODD        = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy,
    output logic       parity,
    output logic       done
);

    localparam int              C_CW      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [C_CW-1:0] C_CNT_MAX = C_CW'(BIT_CYCLES - 1);
    localparam logic            C_ODD     = (ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [C_CW-1:0] r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic            r_done;
    logic            w_tc;
    logic            w_tx;

    assign w_tc = (r_cnt == C_CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_tx   = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (data_valid) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_tc) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (w_tc && (r_bit == 3'd7)) begin
                    w_next = S_PARITY;
                end
            end
            S_PARITY: begin
                w_tx = r_parity;
                if (w_tc) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tc) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: bit timer, bit index, shifter and parity capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_bit    <= 3'd0;
            r_shift  <= 8'd0;
            r_parity <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_STOP) && (w_next == S_IDLE);
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
                r_bit <= 3'd0;
                if (data_valid) begin
                    r_shift  <= data;
                    r_parity <= (^data) ^ C_ODD;
                end
            end else begin
                r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
                if ((r_state == S_DATA) && w_tc) begin
                    r_shift <= {1'b0, r_shift[7:1]};
                    r_bit   <= r_bit + 3'd1;
                end
            end
        end
    end

    assign tx         = w_tx;
    assign data_ready = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign parity     = r_parity;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_frame_tx
// Brief    : Directed self-checking bench for parity_frame_tx (three configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_frame_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] din [3];
    logic [2:0] dv;
    logic [2:0] rdy;
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] par;
    logic [2:0] done;

    int n_vec;
    int n_err;
    int n_done0;

    parity_frame_tx #(.BIT_CYCLES(4), .ODD(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .data(din[0]), .data_valid(dv[0]),
        .data_ready(rdy[0]), .tx(tx[0]), .busy(busy[0]), .parity(par[0]), .done(done[0])
    );
    parity_frame_tx #(.BIT_CYCLES(4), .ODD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data(din[1]), .data_valid(dv[1]),
        .data_ready(rdy[1]), .tx(tx[1]), .busy(busy[1]), .parity(par[1]), .done(done[1])
    );
    parity_frame_tx #(.BIT_CYCLES(1), .ODD(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .data(din[2]), .data_valid(dv[2]),
        .data_ready(rdy[2]), .tx(tx[2]), .busy(busy[2]), .parity(par[2]), .done(done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done[0]) n_done0 = n_done0 + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: drop valid after accept; 1: hold valid; 2: scramble valid/data mid-frame
    task automatic send_frame(input int idx, input int bc, input logic [7:0] b,
                              input logic exp_par, input int mode);
        logic [10:0] exp_bits;
        exp_bits = {1'b1, exp_par, b, 1'b0};
        din[idx] = b;
        dv[idx]  = 1'b1;
        check_value($sformatf("ready_before_%0d_%02h", idx, b), 32'(rdy[idx]), 32'd1);
        tick();
        check_value($sformatf("parity_%0d_%02h", idx, b), 32'(par[idx]), 32'(exp_par));
        for (int cyc = 0; cyc < 11 * bc; cyc++) begin
            check_value($sformatf("tx_%0d_%02h_c%0d", idx, b, cyc),
                        32'(tx[idx]), 32'(exp_bits[cyc / bc]));
            if (cyc == 11 * bc - 1) begin
                check_value($sformatf("busy_last_%0d_%02h", idx, b), 32'(busy[idx]), 32'd1);
                check_value($sformatf("done_early_%0d_%02h", idx, b), 32'(done[idx]), 32'd0);
            end
            if (mode == 0) begin
                dv[idx] = 1'b0;
            end else if (mode == 2) begin
                dv[idx]  = 1'($urandom_range(0, 1));
                din[idx] = 8'($urandom_range(0, 255));
            end
            tick();
        end
        dv[idx] = (mode == 1);
        check_value($sformatf("done_%0d_%02h", idx, b), 32'(done[idx]), 32'd1);
        check_value($sformatf("ready_done_%0d_%02h", idx, b), 32'(rdy[idx]), 32'd1);
        check_value($sformatf("busy_done_%0d_%02h", idx, b), 32'(busy[idx]), 32'd0);
        check_value($sformatf("tx_idle_%0d_%02h", idx, b), 32'(tx[idx]), 32'd1);
    endtask

    initial begin
        int done_base;
        n_vec   = 0;
        n_err   = 0;
        n_done0 = 0;
        rst_n   = 1'b0;
        dv      = 3'b000;
        for (int i = 0; i < 3; i++) din[i] = 8'h00;
        #2;
        for (int i = 0; i < 3; i++) begin
            check_value($sformatf("rst_tx_%0d", i), 32'(tx[i]), 32'd1);
            check_value($sformatf("rst_busy_%0d", i), 32'(busy[i]), 32'd0);
            check_value($sformatf("rst_done_%0d", i), 32'(done[i]), 32'd0);
            check_value($sformatf("rst_ready_%0d", i), 32'(rdy[i]), 32'd1);
            check_value($sformatf("rst_parity_%0d", i), 32'(par[i]), 32'd0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Directed frames with hand-computed parity
        send_frame(0, 4, 8'hA5, 1'b0, 0);
        tick();
        send_frame(0, 4, 8'h07, 1'b1, 0);
        tick();
        check_value("parity_hold_idle", 32'(par[0]), 32'd1);
        send_frame(0, 4, 8'hFF, 1'b0, 0);
        send_frame(1, 4, 8'h00, 1'b1, 0);
        send_frame(2, 1, 8'h81, 1'b0, 0);

        // Mid-frame valid toggling and data changes must not disturb the frame
        send_frame(0, 4, 8'h5A, 1'b0, 2);
        tick();
        check_value("no_extra_accept", 32'(busy[0]), 32'd0);

        // Back-to-back sweep with valid held high
        done_base = n_done0;
        for (int d = 0; d < 256; d++) begin
            send_frame(0, 4, 8'(d), ^(8'(d)), 1);
        end
        dv[0] = 1'b0;
        tick();
        check_value("sweep_done_pulses", 32'(n_done0 - done_base), 32'd256);
        check_value("sweep_idle_after", 32'(busy[0]), 32'd0);

        // Reset during DATA bit 3
        din[0] = 8'hC3;
        dv[0]  = 1'b1;
        tick();
        dv[0] = 1'b0;
        repeat (17) tick();
        check_value("pre_reset_busy", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_value("async_rst_tx", 32'(tx[0]), 32'd1);
        check_value("async_rst_busy", 32'(busy[0]), 32'd0);
        check_value("async_rst_parity", 32'(par[0]), 32'd0);
        tick();
        check_value("rst_no_done", 32'(done[0]), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_value($sformatf("post_rst_done_%0d", i), 32'(done[0]), 32'd0);
            check_value($sformatf("post_rst_busy_%0d", i), 32'(busy[0]), 32'd0);
        end
        send_frame(0, 4, 8'h3C, 1'b0, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parity_frame_tx.md
PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

Interface
REQ-001 The block SHALL have parameter BIT_CYCLES, default 4: clock cycles per serial bit, legal range 1..1024.
REQ-002 The block SHALL have parameter ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 data  input  8  byte to transmit; sampled only on acceptance.
REQ-006 data_valid  input  1  requester has a byte on data.
REQ-007 data_ready  output  1  block can accept a byte; high only in IDLE.
REQ-008 tx  output  1  serial line; idles high.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 parity  output  8->1  registered parity bit of the last accepted byte.
REQ-011 done  output  1  one-cycle pulse on frame completion.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, and every output SHALL be driven from registers or decoded from state only.
REQ-013 Acceptance SHALL occur on a rising edge where data_valid=1 and data_ready=1. On that edge the block SHALL capture data into a shift register, load parity = (^data) ^ ODD, and move to START.
REQ-014 data_valid SHALL be ignored outside IDLE. A change on data after acceptance SHALL NOT affect the frame in flight.
REQ-015 In START, tx SHALL be 0 for exactly BIT_CYCLES cycles.
REQ-016 In DATA, the block SHALL send 8 bits LSB first, each held for BIT_CYCLES cycles. A 3-bit bit index SHALL run 0..7, and the transition to PARITY SHALL occur after index 7 completes.
REQ-017 In PARITY, tx SHALL equal the parity register for BIT_CYCLES cycles.
REQ-018 In STOP, tx SHALL be 1 for BIT_CYCLES cycles, after which the FSM SHALL return to IDLE.
REQ-019 A bit-period counter SHALL count 0..BIT_CYCLES-1 and advance state or bit on its terminal count. With BIT_CYCLES=1, every bit SHALL last exactly one cycle.
REQ-020 Frame length SHALL be 11*BIT_CYCLES cycles from the accept edge to the edge that re-enters IDLE.
REQ-021 done SHALL be 1 for exactly the first cycle back in IDLE and 0 at all other times.
REQ-022 data_ready SHALL be high in the same cycle as done, so a new byte can be accepted immediately. This gives a minimum inter-frame gap of one idle cycle with tx=1.
REQ-023 In IDLE, tx SHALL be 1 and the parity register SHALL hold its last value.

Reset
REQ-024 While rst_n=0, the block SHALL immediately force: state=IDLE, tx=1, busy=0, done=0, data_ready=1, parity=0, counters=0, shift register=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no done pulse. After release, the first edge with data_valid=1 SHALL start a fresh frame.

Verification (BIT_CYCLES=4, ODD=0 unless stated; accept edge = k)
REQ-026 Byte 8'hA5 accepted at k:
- tx, per 4-cycle bit from edge k: 0 | 1,0,1,0,0,1,0,1 | 0 | 1.
- parity=0.
- done=1 only in the cycle after edge k+44.
REQ-027 Byte 8'h07:
- parity bit = 1.
- Byte 8'hFF then gives parity bit = 0.
- With ODD=1, byte 8'h00 gives parity bit = 1.
REQ-028 Exhaustive sweep of data 0..255, back-to-back with data_valid held high:
- the parity bit of each frame SHALL equal ^data;
- frames SHALL be separated by exactly one idle cycle;
- there SHALL be 256 done pulses.
REQ-029 During a frame, toggle data_valid and change data: no extra acceptance, and the serial bits SHALL be unchanged.
REQ-030 Assert rst_n=0 during DATA bit 3:
- tx=1 and busy=0 asynchronously;
- no done pulse;
- the next accepted byte (8'h3C) SHALL produce a correct full frame.
REQ-031 With BIT_CYCLES=1, byte 8'h81 SHALL produce an 11-cycle frame: 0,1,0,0,0,0,0,0,1,0,1.
